rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back arbiter with clear sweep
// Clears x1..x31 after reset, then round-robin grants N_REQ write-back requesters onto one registered write port.
module rf_wb_arbiter #(
  parameter int DATA_N = 32,
  parameter int N_REQ  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [5*N_REQ-1:0]       req_addr,
  input  logic [DATA_N*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     wr_en,
  output logic [4:0]               w_addr,
  output logic [DATA_N-1:0]        w_data,
  output logic                     init_done,
  output logic [7:0]               x0_drop_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_sweep;
  logic [IDX_W-1:0]    r_last;
  logic                r_wr_en;
  logic [4:0]          r_w_addr;
  logic [DATA_N-1:0]   r_w_data;
  logic                r_init_done;
  logic [7:0]          r_drop;

  logic                w_found;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_cand;
  logic [N_REQ-1:0]    w_grant;
  logic                w_accept;
  logic [4:0]          w_sel_addr;
  logic [DATA_N-1:0]   w_sel_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_sweep == 5'd31) w_state_nxt = ST_RUN;
  end

  // Search starts one past the last granted requester so every requester is visited in turn.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (rst_n && r_state == ST_RUN && !hold && w_found) w_grant = N_REQ'(1) << w_idx;
  end

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_addr = req_addr[5*i +: 5];
        w_sel_data = req_data[DATA_N*i +: DATA_N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sweep     <= 5'd1;
      r_last      <= IDX_W'(N_REQ - 1);
      r_wr_en     <= 1'b0;
      r_w_addr    <= '0;
      r_w_data    <= '0;
      r_init_done <= 1'b0;
      r_drop      <= '0;
    end else if (r_state == ST_INIT) begin
      r_wr_en     <= 1'b1;
      r_w_addr    <= r_sweep;
      r_w_data    <= '0;
      r_sweep     <= r_sweep + 5'd1;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
      r_wr_en     <= 1'b0;
      if (w_accept) begin
        r_last <= w_idx;
        // x0 is hardwired zero: consume the request but never write it.
        if (w_sel_addr != 5'd0) begin
          r_wr_en  <= 1'b1;
          r_w_addr <= w_sel_addr;
          r_w_data <= w_sel_data;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign w_addr      = r_w_addr;
  assign w_data      = r_w_data;
  assign init_done   = r_init_done;
  assign x0_drop_cnt = r_drop;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
// Stimulus pushes expected write-port state per cycle; a monitor pops and compares after each edge.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [5*NR-1:0]   req_addr = '0;
  logic [DW*NR-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              wr_en;
  logic [4:0]        w_addr;
  logic [DW-1:0]     w_data;
  logic              init_done;
  logic [7:0]        x0_drop_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_N(DW), .N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .init_done(init_done), .x0_drop_cnt(x0_drop_cnt)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        idone;
    logic [7:0]  drop;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  logic              s_rst_n = 1'b0;
  logic              s_hold = 1'b0;
  logic [NR-1:0]     s_valid = '0;
  logic [5*NR-1:0]   s_addr = '0;
  logic [DW*NR-1:0]  s_data = '0;

  bit          m_run = 0;
  int          m_sweep = 1;
  int          m_last = NR - 1;
  int          m_drop = 0;
  bit          m_idone = 0;
  logic        m_wr = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick();
    if (!s_rst_n || !m_run || s_hold) return -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_last + k) % NR;
      if (s_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [4:0] a;
    exp_t e;
    @(negedge clk);
    rst_n = s_rst_n; hold = s_hold; req_valid = s_valid; req_addr = s_addr; req_data = s_data;
    #1;
    g = pick();
    check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (!s_rst_n) begin
      m_run = 0; m_sweep = 1; m_last = NR - 1; m_drop = 0; m_idone = 0;
      m_wr = 0; m_addr = 0; m_data = 0;
    end else if (!m_run) begin
      m_idone = 0; m_wr = 1; m_addr = 5'(m_sweep); m_data = 0;
      if (m_sweep == 31) m_run = 1; else m_sweep++;
    end else begin
      m_idone = 1; m_wr = 0;
      if (g >= 0) begin
        m_last = g;
        a = s_addr[5*g +: 5];
        if (a != 0) begin
          m_wr = 1; m_addr = a; m_data = s_data[DW*g +: DW];
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    e.wr = m_wr; e.addr = m_addr; e.data = m_data; e.idone = m_idone; e.drop = 8'(m_drop);
    q.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("wr_en", 64'(wr_en), 64'(e.wr));
      check("w_addr", 64'(w_addr), 64'(e.addr));
      check("w_data", 64'(w_data), 64'(e.data));
      check("init_done", 64'(init_done), 64'(e.idone));
      check("x0_drop_cnt", 64'(x0_drop_cnt), 64'(e.drop));
    end
  end

  initial begin
    s_valid = '1;
    s_addr  = {5'd7, 5'd6, 5'd5};
    s_data  = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    repeat (3) step();
    s_rst_n = 1'b1;
    repeat (40) step();
    s_hold = 1'b1;
    repeat (4) step();
    s_hold = 1'b0;
    repeat (5) step();
    repeat (300) begin
      s_valid = NR'($urandom);
      s_hold  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NR; i++) begin
        s_addr[5*i +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s_data[DW*i +: DW] = $urandom;
      end
      step();
    end
    s_hold  = 1'b0;
    s_valid = 3'b010;
    s_addr  = {5'd7, 5'd0, 5'd5};
    repeat (300) step();
    s_valid = '1;
    s_addr  = {5'd9, 5'd10, 5'd11};
    step();
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    repeat (10) step();
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    repeat (40) step();
    s_valid = '0;
    repeat (2) step();
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
